// File: rtl/ahci_fis_rx_responder.sv
// Device-to-host FIS responder: latches the FIS header, waits for a get_* command,
// then stores or drops the FIS and reports done/ok/err/ferr with latched TFD/PIO fields.
//   state   | meaning
//   S_IDLE  | waiting for a first DWORD, other DWORDs are dropped
//   S_HDR   | header held, waiting for a command
//   S_STORE | writing DWORDs into the received-FIS area
//   S_SKIP  | dropping DWORDs until the last one
//   S_FIN   | one-cycle result, commit and signature write
module ahci_fis_rx_responder #(
  parameter int                      ADDRESS_BITS = 10,
  parameter logic [ADDRESS_BITS-1:0] RFIS_BASE    = 10'h380,
  parameter logic [ADDRESS_BITS-1:0] PXSIG_ADDR   = 10'h049,
  parameter int                      UFIS_MAX     = 16
) (
  input  logic                    mclk,
  input  logic                    hba_rst,
  input  logic [31:0]             d2h_data,
  input  logic [1:0]              d2h_type,
  input  logic                    d2h_valid,
  input  logic                    d2h_crc_err,
  output logic                    d2h_ready,
  output logic                    fis_first_vld,
  output logic [7:0]              fis_type,
  input  logic                    get_sig,
  input  logic                    get_dsfis,
  input  logic                    get_psfis,
  input  logic                    get_rfis,
  input  logic                    get_sdbfis,
  input  logic                    get_ufis,
  input  logic                    get_ignore,
  output logic                    get_fis_busy,
  output logic                    get_fis_done,
  output logic                    fis_ok,
  output logic                    fis_err,
  output logic                    fis_ferr,
  output logic [ADDRESS_BITS-1:0] regs_addr,
  output logic                    regs_we,
  output logic [31:0]             regs_din,
  output logic [7:0]              tfd_sts,
  output logic [7:0]              tfd_err,
  output logic                    fis_i,
  output logic                    sdb_n,
  output logic                    dma_a,
  output logic                    dma_d,
  output logic                    pio_i,
  output logic                    pio_d,
  output logic [7:0]              pio_es,
  output logic [15:0]             xfer_cntr
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STORE, S_SKIP, S_FIN} state_t;
  typedef enum logic [2:0] {K_DS, K_PS, K_RFIS, K_SDB, K_UFIS, K_IGN} kind_t;

  state_t                  state_q;
  kind_t                   kind_q, cmd_kind_d;
  logic [31:0]             hdr_q;
  logic                    single_q, sig_q, crc_q, short_q, ferr_q;
  logic [4:0]              exp_len_q, idx_q, cmd_len_d;
  logic [ADDRESS_BITS-1:0] base_q, cmd_off_d;
  logic                    cmd_vld_d, cmd_sig_d;
  logic [23:0]             sig_lba_q;
  logic [7:0]              sig_sc_q;
  logic [7:0]              sh_sts_q, sh_err_q, sh_es_q;
  logic                    sh_i_q, sh_n_q, sh_a_q, sh_dd_q, sh_pi_q, sh_pd_q;
  logic [15:0]             sh_xfer_q;
  logic                    acc, last;

  assign acc  = d2h_valid && d2h_ready;
  assign last = d2h_type[1];

  always_comb begin
    cmd_vld_d  = get_sig | get_dsfis | get_psfis | get_rfis | get_sdbfis | get_ufis | get_ignore;
    cmd_kind_d = K_IGN;
    cmd_len_d  = 5'd0;
    cmd_off_d  = '0;
    cmd_sig_d  = 1'b0;
    if (get_sig) begin
      cmd_kind_d = K_RFIS; cmd_len_d = 5'd5; cmd_off_d = ADDRESS_BITS'(16); cmd_sig_d = 1'b1;
    end else if (get_dsfis) begin
      cmd_kind_d = K_DS;   cmd_len_d = 5'd7; cmd_off_d = ADDRESS_BITS'(0);
    end else if (get_psfis) begin
      cmd_kind_d = K_PS;   cmd_len_d = 5'd5; cmd_off_d = ADDRESS_BITS'(8);
    end else if (get_rfis) begin
      cmd_kind_d = K_RFIS; cmd_len_d = 5'd5; cmd_off_d = ADDRESS_BITS'(16);
    end else if (get_sdbfis) begin
      cmd_kind_d = K_SDB;  cmd_len_d = 5'd2; cmd_off_d = ADDRESS_BITS'(22);
    end else if (get_ufis) begin
      cmd_kind_d = K_UFIS; cmd_len_d = 5'(UFIS_MAX); cmd_off_d = ADDRESS_BITS'(24);
    end
  end

  always_ff @(posedge mclk) begin
    if (hba_rst) begin
      state_q <= S_IDLE;  kind_q <= K_IGN;   hdr_q <= '0;
      single_q <= 1'b0;   sig_q <= 1'b0;     crc_q <= 1'b0;
      short_q <= 1'b0;    ferr_q <= 1'b0;    exp_len_q <= '0;
      idx_q <= '0;        base_q <= '0;      sig_lba_q <= '0;
      sig_sc_q <= '0;     sh_sts_q <= 8'h7f; sh_err_q <= '0;
      sh_es_q <= '0;      sh_i_q <= 1'b0;    sh_n_q <= 1'b0;
      sh_a_q <= 1'b0;     sh_dd_q <= 1'b0;   sh_pi_q <= 1'b0;
      sh_pd_q <= 1'b0;    sh_xfer_q <= '0;
      d2h_ready <= 1'b1;  fis_first_vld <= 1'b0; fis_type <= '0;
      get_fis_busy <= 1'b0; get_fis_done <= 1'b0;
      fis_ok <= 1'b0;     fis_err <= 1'b0;   fis_ferr <= 1'b0;
      regs_addr <= '0;    regs_we <= 1'b0;   regs_din <= '0;
      tfd_sts <= 8'h7f;   tfd_err <= '0;     fis_i <= 1'b0;
      sdb_n <= 1'b0;      dma_a <= 1'b0;     dma_d <= 1'b0;
      pio_i <= 1'b0;      pio_d <= 1'b0;     pio_es <= '0;
      xfer_cntr <= '0;
    end else begin
      get_fis_done <= 1'b0;
      regs_we      <= 1'b0;
      case (state_q)
        S_IDLE: if (acc && d2h_type[0]) begin
          hdr_q         <= d2h_data;
          fis_type      <= d2h_data[7:0];
          single_q      <= last;
          crc_q         <= last && d2h_crc_err;
          fis_first_vld <= 1'b1;
          d2h_ready     <= 1'b0;
          state_q       <= S_HDR;
        end
        S_HDR: if (cmd_vld_d) begin
          fis_first_vld <= 1'b0;
          get_fis_busy  <= 1'b1;
          fis_ok <= 1'b0; fis_err <= 1'b0; fis_ferr <= 1'b0;
          kind_q    <= cmd_kind_d;
          sig_q     <= cmd_sig_d;
          exp_len_q <= cmd_len_d;
          base_q    <= RFIS_BASE + cmd_off_d;
          idx_q     <= 5'd1;
          ferr_q    <= 1'b0;
          short_q   <= single_q && (5'd1 < cmd_len_d) && (cmd_kind_d != K_UFIS);
          sh_sts_q <= tfd_sts; sh_err_q <= tfd_err; sh_es_q <= pio_es; sh_xfer_q <= xfer_cntr;
          sh_i_q <= fis_i; sh_n_q <= sdb_n; sh_a_q <= dma_a; sh_dd_q <= dma_d;
          sh_pi_q <= pio_i; sh_pd_q <= pio_d;
          if (cmd_kind_d != K_IGN) begin
            regs_we   <= 1'b1;
            regs_addr <= RFIS_BASE + cmd_off_d;
            regs_din  <= hdr_q;
          end
          if (single_q) state_q <= S_FIN;
          else begin
            d2h_ready <= 1'b1;
            state_q   <= (cmd_kind_d == K_IGN) ? S_SKIP : S_STORE;
          end
        end
        S_STORE: if (acc) begin
          if (idx_q == exp_len_q) begin
            // one DWORD more than the FIS type allows
            ferr_q  <= 1'b1;
            state_q <= S_SKIP;
          end else begin
            regs_we   <= 1'b1;
            regs_addr <= base_q + ADDRESS_BITS'(idx_q);
            regs_din  <= d2h_data;
            idx_q     <= idx_q + 5'd1;
            if (idx_q == 5'd1) begin
              sh_i_q <= hdr_q[14];
              if (sig_q) sig_lba_q <= d2h_data[23:0];
              case (kind_q)
                K_DS:   begin sh_dd_q <= hdr_q[13]; sh_a_q <= hdr_q[15]; end
                K_PS:   begin
                  sh_pd_q <= hdr_q[13]; sh_pi_q <= hdr_q[14];
                  sh_sts_q <= hdr_q[23:16]; sh_err_q <= hdr_q[31:24];
                end
                K_RFIS: begin sh_sts_q <= hdr_q[23:16]; sh_err_q <= hdr_q[31:24]; end
                K_SDB:  begin
                  sh_n_q   <= hdr_q[15];
                  sh_sts_q <= (sh_sts_q & 8'h88) | (hdr_q[23:16] & 8'h77);
                  sh_err_q <= hdr_q[31:24];
                end
                default: ;
              endcase
            end
            if (idx_q == 5'd3 && sig_q) sig_sc_q <= d2h_data[7:0];
            if (idx_q == 5'd3 && kind_q == K_PS) sh_es_q <= d2h_data[31:24];
            if (idx_q == 5'd4 && kind_q == K_PS) sh_xfer_q <= d2h_data[15:0];
            if (last) short_q <= ((idx_q + 5'd1) < exp_len_q) && (kind_q != K_UFIS);
          end
          if (last) begin
            crc_q     <= d2h_crc_err;
            d2h_ready <= 1'b0;
            state_q   <= S_FIN;
          end
        end
        S_SKIP: if (acc && last) begin
          crc_q     <= d2h_crc_err;
          d2h_ready <= 1'b0;
          state_q   <= S_FIN;
        end
        S_FIN: begin
          get_fis_done <= 1'b1;
          get_fis_busy <= 1'b0;
          d2h_ready    <= 1'b1;
          state_q      <= S_IDLE;
          if (ferr_q) fis_ferr <= 1'b1;
          else if (crc_q || short_q) fis_err <= 1'b1;
          else begin
            fis_ok  <= 1'b1;
            tfd_sts <= sh_sts_q; tfd_err <= sh_err_q; pio_es <= sh_es_q; xfer_cntr <= sh_xfer_q;
            fis_i <= sh_i_q; sdb_n <= sh_n_q; dma_a <= sh_a_q; dma_d <= sh_dd_q;
            pio_i <= sh_pi_q; pio_d <= sh_pd_q;
            if (sig_q) begin
              regs_we   <= 1'b1;
              regs_addr <= PXSIG_ADDR;
              regs_din  <= {sig_sc_q, sig_lba_q};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahci_fis_rx_responder.sv
// Directed bench for ahci_fis_rx_responder: streams hand-built FISes and compares
// register writes, results and latched fields against hand-computed values.
module tb_ahci_fis_rx_responder;

  logic        mclk = 1'b0;
  logic        hba_rst;
  logic [31:0] d2h_data;
  logic [1:0]  d2h_type;
  logic        d2h_valid, d2h_crc_err, d2h_ready;
  logic        fis_first_vld;
  logic [7:0]  fis_type;
  logic        get_sig, get_dsfis, get_psfis, get_rfis, get_sdbfis, get_ufis, get_ignore;
  logic        get_fis_busy, get_fis_done, fis_ok, fis_err, fis_ferr;
  logic [9:0]  regs_addr;
  logic        regs_we;
  logic [31:0] regs_din;
  logic [7:0]  tfd_sts, tfd_err, pio_es;
  logic        fis_i, sdb_n, dma_a, dma_d, pio_i, pio_d;
  logic [15:0] xfer_cntr;

  ahci_fis_rx_responder dut (
    .mclk(mclk), .hba_rst(hba_rst), .d2h_data(d2h_data), .d2h_type(d2h_type),
    .d2h_valid(d2h_valid), .d2h_crc_err(d2h_crc_err), .d2h_ready(d2h_ready),
    .fis_first_vld(fis_first_vld), .fis_type(fis_type),
    .get_sig(get_sig), .get_dsfis(get_dsfis), .get_psfis(get_psfis), .get_rfis(get_rfis),
    .get_sdbfis(get_sdbfis), .get_ufis(get_ufis), .get_ignore(get_ignore),
    .get_fis_busy(get_fis_busy), .get_fis_done(get_fis_done),
    .fis_ok(fis_ok), .fis_err(fis_err), .fis_ferr(fis_ferr),
    .regs_addr(regs_addr), .regs_we(regs_we), .regs_din(regs_din),
    .tfd_sts(tfd_sts), .tfd_err(tfd_err), .fis_i(fis_i), .sdb_n(sdb_n),
    .dma_a(dma_a), .dma_d(dma_d), .pio_i(pio_i), .pio_d(pio_d),
    .pio_es(pio_es), .xfer_cntr(xfer_cntr)
  );

  always #5 mclk = ~mclk;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [9:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] fis_dw[8];

  always @(negedge mclk) begin
    if (regs_we) begin
      wr_a.push_back(regs_addr);
      wr_d.push_back(regs_din);
    end
    if (get_fis_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_dw(input logic [31:0] d, input logic [1:0] t, input logic crc);
    int n = 0;
    d2h_data = d; d2h_type = t; d2h_crc_err = crc; d2h_valid = 1'b1;
    while (!d2h_ready && n < 50) begin @(negedge mclk); n++; end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge mclk);
    d2h_valid = 1'b0; d2h_crc_err = 1'b0;
  endtask

  // cmd: 0 rfis, 1 sig, 2 psfis, 3 sdbfis, 4 ignore
  task automatic pulse_cmd(input int cmd);
    int n = 0;
    while (!fis_first_vld && n < 50) begin @(negedge mclk); n++; end
    if (n >= 50) check("hdr_timeout", 32'd0, 32'd1);
    case (cmd)
      0: get_rfis = 1'b1;
      1: get_sig = 1'b1;
      2: get_psfis = 1'b1;
      3: get_sdbfis = 1'b1;
      default: get_ignore = 1'b1;
    endcase
    @(negedge mclk);
    {get_sig, get_dsfis, get_psfis, get_rfis, get_sdbfis, get_ufis, get_ignore} = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!get_fis_done && n < 60) begin @(negedge mclk); n++; end
    if (n >= 60) check("done_timeout", 32'd0, 32'd1);
    #1;
  endtask

  // sends header, issues command, streams the rest and waits for done
  task automatic run_fis(input int ndw, input int cmd, input logic crc_last);
    send_dw(fis_dw[0], (ndw == 1) ? 2'b11 : 2'b01, 1'b0);
    pulse_cmd(cmd);
    for (int i = 1; i < ndw; i++)
      send_dw(fis_dw[i], (i == ndw - 1) ? 2'b10 : 2'b00, crc_last && (i == ndw - 1));
    wait_done();
  endtask

  task automatic check_wr(input int start, input int nexp, input logic [9:0] base);
    check("wr_count", 32'(wr_a.size() - start), 32'(nexp));
    for (int i = 0; i < nexp && start + i < wr_a.size(); i++) begin
      check("wr_addr", 32'(wr_a[start+i]), 32'(base + 10'(i)));
      check("wr_data", wr_d[start+i], fis_dw[i]);
    end
  endtask

  task automatic check_result(input logic ok, input logic err, input logic ferr, input int dstart);
    check("fis_ok", 32'(fis_ok), 32'(ok));
    check("fis_err", 32'(fis_err), 32'(err));
    check("fis_ferr", 32'(fis_ferr), 32'(ferr));
    repeat (3) @(negedge mclk);
    #1;
    check("done_pulses", 32'(done_cnt - dstart), 32'd1);
    check("busy_after", 32'(get_fis_busy), 32'd0);
  endtask

  int ws, ds;

  initial begin
    hba_rst = 1'b1; d2h_valid = 1'b0; d2h_data = '0; d2h_type = '0; d2h_crc_err = 1'b0;
    {get_sig, get_dsfis, get_psfis, get_rfis, get_sdbfis, get_ufis, get_ignore} = '0;
    repeat (3) @(negedge mclk);
    hba_rst = 1'b0;
    #1;
    check("rst_ready", 32'(d2h_ready), 32'd1);
    check("rst_tfd_sts", 32'(tfd_sts), 32'h7f);
    check("rst_busy", 32'(get_fis_busy), 32'd0);
    check("rst_first_vld", 32'(fis_first_vld), 32'd0);
    check("rst_ok", 32'(fis_ok), 32'd0);
    check("rst_we", 32'(regs_we), 32'd0);
    @(negedge mclk);

    // RFIS with get_rfis
    fis_dw[0] = 32'h00504034; fis_dw[1] = 32'h1; fis_dw[2] = 32'h0;
    fis_dw[3] = 32'h1;        fis_dw[4] = 32'h0;
    ws = wr_a.size(); ds = done_cnt;
    send_dw(fis_dw[0], 2'b01, 1'b0);
    check("hdr_first_vld", 32'(fis_first_vld), 32'd1);
    check("hdr_fis_type", 32'(fis_type), 32'h34);
    check("hdr_ready", 32'(d2h_ready), 32'd0);
    pulse_cmd(0);
    check("store_busy", 32'(get_fis_busy), 32'd1);
    for (int i = 1; i < 5; i++) send_dw(fis_dw[i], (i == 4) ? 2'b10 : 2'b00, 1'b0);
    wait_done();
    check_wr(ws, 5, 10'h390);
    check("rfis_tfd_sts", 32'(tfd_sts), 32'h50);
    check("rfis_tfd_err", 32'(tfd_err), 32'h00);
    check("rfis_fis_i", 32'(fis_i), 32'd1);
    check_result(1'b1, 1'b0, 1'b0, ds);

    // same RFIS with get_sig
    ws = wr_a.size(); ds = done_cnt;
    run_fis(5, 1, 1'b0);
    check("sig_wr_count", 32'(wr_a.size() - ws), 32'd6);
    if (wr_a.size() >= ws + 6) begin
      check("sig_wr3_addr", 32'(wr_a[ws+3]), 32'h393);
      check("sig_pxsig_addr", 32'(wr_a[ws+5]), 32'h049);
      check("sig_pxsig_data", wr_d[ws+5], 32'h01000001);
    end
    check_result(1'b1, 1'b0, 1'b0, ds);

    // PSFIS with E_Status and transfer count
    fis_dw[0] = 32'h0150605F; fis_dw[1] = 32'h0; fis_dw[2] = 32'h0;
    fis_dw[3] = 32'h58000000; fis_dw[4] = 32'h00000200;
    ws = wr_a.size(); ds = done_cnt;
    run_fis(5, 2, 1'b0);
    check_wr(ws, 5, 10'h388);
    check("ps_pio_es", 32'(pio_es), 32'h58);
    check("ps_xfer_cntr", 32'(xfer_cntr), 32'h0200);
    check("ps_pio_d", 32'(pio_d), 32'd1);
    check("ps_pio_i", 32'(pio_i), 32'd1);
    check("ps_tfd_err", 32'(tfd_err), 32'h01);
    check_result(1'b1, 1'b0, 1'b0, ds);

    // RFIS too long: 7 DWORDs
    fis_dw[0] = 32'h00414034; fis_dw[1] = 32'h2; fis_dw[2] = 32'h3; fis_dw[3] = 32'h4;
    fis_dw[4] = 32'h5; fis_dw[5] = 32'h6; fis_dw[6] = 32'h7;
    ws = wr_a.size(); ds = done_cnt;
    run_fis(7, 0, 1'b0);
    check_wr(ws, 5, 10'h390);
    check("long_tfd_sts", 32'(tfd_sts), 32'h50);
    check("long_tfd_err", 32'(tfd_err), 32'h01);
    check_result(1'b0, 1'b0, 1'b1, ds);

    // SDB with CRC error on the last DWORD
    fis_dw[0] = 32'h00FFC0A1; fis_dw[1] = 32'h0;
    ws = wr_a.size(); ds = done_cnt;
    run_fis(2, 3, 1'b1);
    check_wr(ws, 2, 10'h396);
    check("sdbcrc_tfd_sts", 32'(tfd_sts), 32'h50);
    check("sdbcrc_sdb_n", 32'(sdb_n), 32'd0);
    check_result(1'b0, 1'b1, 1'b0, ds);

    // clean SDB: status bits 7 and 3 keep their old value
    ds = done_cnt;
    run_fis(2, 3, 1'b0);
    check("sdb_tfd_sts", 32'(tfd_sts), 32'h77);
    check("sdb_tfd_err", 32'(tfd_err), 32'h00);
    check("sdb_sdb_n", 32'(sdb_n), 32'd1);
    check_result(1'b1, 1'b0, 1'b0, ds);

    // RFIS too short: 3 DWORDs
    fis_dw[0] = 32'h00204034; fis_dw[1] = 32'h0; fis_dw[2] = 32'h0;
    ds = done_cnt;
    run_fis(3, 0, 1'b0);
    check("short_tfd_sts", 32'(tfd_sts), 32'h77);
    check_result(1'b0, 1'b1, 1'b0, ds);

    // get_ignore with 3 trailing DWORDs
    fis_dw[0] = 32'h00000039; fis_dw[1] = 32'h11; fis_dw[2] = 32'h22; fis_dw[3] = 32'h33;
    ws = wr_a.size(); ds = done_cnt;
    run_fis(4, 4, 1'b0);
    check("ign_wr_count", 32'(wr_a.size() - ws), 32'd0);
    check_result(1'b1, 1'b0, 1'b0, ds);

    // single-DWORD FIS ignored
    fis_dw[0] = 32'h000000A1;
    ws = wr_a.size(); ds = done_cnt;
    run_fis(1, 4, 1'b0);
    check("single_wr_count", 32'(wr_a.size() - ws), 32'd0);
    check_result(1'b1, 1'b0, 1'b0, ds);

    // reset in the middle of STORE
    ds = done_cnt;
    send_dw(32'h00504034, 2'b01, 1'b0);
    pulse_cmd(0);
    send_dw(32'h1, 2'b00, 1'b0);
    send_dw(32'h2, 2'b00, 1'b0);
    hba_rst = 1'b1;
    @(negedge mclk);
    hba_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(get_fis_busy), 32'd0);
    check("midrst_tfd_sts", 32'(tfd_sts), 32'h7f);
    check("midrst_ready", 32'(d2h_ready), 32'd1);
    repeat (5) @(negedge mclk);
    #1;
    check("midrst_no_done", 32'(done_cnt - ds), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
